// File: rtl/bnn_dot_word_feeder_pkg.sv
// Shared defaults, result width and FSM state type for the BNN dot-product word feeder.
package bnn_dot_word_feeder_pkg;

    localparam int unsigned WORD_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned LEN_W_DEF  = 8;
    localparam int unsigned ACC_W      = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_DONE,
        S_RESP
    } feed_state_t;

endpackage

// File: rtl/bnn_feed_addr_ctr.sv
// Activation/weight read-address generator: loads bases, walks len words with modulo wrap,
// and delays the read strobe/last flag one cycle so they line up with SRAM read data.
module bnn_feed_addr_ctr
    import bnn_dot_word_feeder_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [LEN_W-1:0]  len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              rd_last,
    output logic              word_valid,
    output logic              last_word
);

    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] len_m1;

    assign rd_last = rd_en && (idx == len_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en      <= 1'b0;
            a_addr     <= '0;
            w_addr     <= '0;
            idx        <= '0;
            len_m1     <= '0;
            word_valid <= 1'b0;
            last_word  <= 1'b0;
        end else begin
            word_valid <= rd_en;
            last_word  <= rd_last;
            if (load) begin
                rd_en  <= 1'b1;
                a_addr <= a_base;
                w_addr <= w_base;
                idx    <= '0;
                len_m1 <= len - LEN_W'(1);
            end else if (rd_en) begin
                if (rd_last) begin
                    rd_en <= 1'b0;
                end else begin
                    idx    <= idx + LEN_W'(1);
                    a_addr <= a_addr + ADDR_W'(1);
                    w_addr <= w_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bnn_dot_word_feeder.sv
// Command-driven streamer feeding the XNOR-popcount dot unit from activation/weight SRAMs.
// Optional threshold sign output enabled by defining BNN_FEED_SIGN_OUT_EN.
module bnn_dot_word_feeder
    import bnn_dot_word_feeder_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_W-1:0]       cmd_a_base,
    input  logic [ADDR_W-1:0]       cmd_w_base,
    input  logic [LEN_W-1:0]        cmd_len,
`ifdef BNN_FEED_SIGN_OUT_EN
    input  logic signed [ACC_W-1:0] cmd_thresh,
`endif
    output logic                    a_rd_en,
    output logic [ADDR_W-1:0]       a_addr,
    input  logic [WORD_W-1:0]       a_rdata,
    output logic                    w_rd_en,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [WORD_W-1:0]       w_rdata,
    output logic                    dot_start,
    output logic [WORD_W-1:0]       dot_a_word,
    output logic [WORD_W-1:0]       dot_w_word,
    output logic                    dot_word_valid,
    output logic                    dot_last_word,
    input  logic                    dot_done,
    input  logic signed [ACC_W-1:0] dot_acc,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
`ifdef BNN_FEED_SIGN_OUT_EN
    output logic                    rsp_bit,
`endif
    output logic signed [ACC_W-1:0] rsp_acc
);

    feed_state_t state;
    feed_state_t state_next;
    logic        accept;
    logic        capture;
    logic        len_zero;
    logic        rd_en;
    logic        rd_last;

    assign len_zero   = (cmd_len == '0);
    assign a_rd_en    = rd_en;
    assign w_rd_en    = rd_en;
    assign dot_a_word = a_rdata;
    assign dot_w_word = w_rdata;

    bnn_feed_addr_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept && !len_zero),
        .a_base     (cmd_a_base),
        .w_base     (cmd_w_base),
        .len        (cmd_len),
        .rd_en      (rd_en),
        .a_addr     (a_addr),
        .w_addr     (w_addr),
        .rd_last    (rd_last),
        .word_valid (dot_word_valid),
        .last_word  (dot_last_word)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept     = 1'b1;
                    state_next = len_zero ? S_RESP : S_START;
                end
            end
            S_START:     state_next = rd_last ? S_WAIT_DONE : S_STREAM;
            S_STREAM:    if (rd_last) state_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (dot_done) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP:      if (rsp_ready) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Strobes are registered from the next state so each is high exactly while its state is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            dot_start <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_acc   <= '0;
        end else begin
            cmd_ready <= (state_next == S_IDLE);
            dot_start <= (state_next == S_START);
            rsp_valid <= (state_next == S_RESP);
            if (accept && len_zero) rsp_acc <= '0;
            else if (capture)       rsp_acc <= dot_acc;
        end
    end

`ifdef BNN_FEED_SIGN_OUT_EN
    logic signed [ACC_W-1:0] thresh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_q <= '0;
            rsp_bit  <= 1'b0;
        end else if (accept) begin
            thresh_q <= cmd_thresh;
            if (len_zero) rsp_bit <= (cmd_thresh <= 0);
        end else if (capture) begin
            rsp_bit <= (dot_acc >= thresh_q);
        end
    end
`endif

endmodule

// File: tb/tb_bnn_dot_word_feeder.sv
// Self-checking bench: SRAM and two-stage dot-unit models, table of commands, scoreboard on rsp port.
module tb_bnn_dot_word_feeder;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 8;
    localparam int PAT_EQ   = 0;
    localparam int PAT_NOT  = 1;
    localparam int PAT_POP  = 2;
    localparam int PAT_ONES = 3;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic [ADDR_W-1:0]        cmd_a_base = '0;
    logic [ADDR_W-1:0]        cmd_w_base = '0;
    logic [LEN_W-1:0]         cmd_len = '0;
    logic                     a_rd_en, w_rd_en;
    logic [ADDR_W-1:0]        a_addr, w_addr;
    logic [WORD_W-1:0]        a_rdata = '0;
    logic [WORD_W-1:0]        w_rdata = '0;
    logic                     dot_start, dot_word_valid, dot_last_word;
    logic [WORD_W-1:0]        dot_a_word, dot_w_word;
    logic                     dot_done = 1'b0;
    logic signed [31:0]       dot_acc = '0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b1;
    logic signed [31:0]       rsp_acc;

    always #5 clk = ~clk;

    bnn_dot_word_feeder #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a_base     (cmd_a_base),
        .cmd_w_base     (cmd_w_base),
        .cmd_len        (cmd_len),
        .a_rd_en        (a_rd_en),
        .a_addr         (a_addr),
        .a_rdata        (a_rdata),
        .w_rd_en        (w_rd_en),
        .w_addr         (w_addr),
        .w_rdata        (w_rdata),
        .dot_start      (dot_start),
        .dot_a_word     (dot_a_word),
        .dot_w_word     (dot_w_word),
        .dot_word_valid (dot_word_valid),
        .dot_last_word  (dot_last_word),
        .dot_done       (dot_done),
        .dot_acc        (dot_acc),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_acc        (rsp_acc)
    );

    logic [31:0] a_mem [1024];
    logic [31:0] w_mem [1024];

    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= a_mem[a_addr];
        if (w_rd_en) w_rdata <= w_mem[w_addr];
    end

    function automatic int contrib(input logic [31:0] a, input logic [31:0] w);
        return 2 * $countones(~(a ^ w)) - 32;
    endfunction

    // Dot unit model: accumulate stage, then a registered result stage.
    int   acc_r;
    logic done_p;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= 0;
            done_p   <= 1'b0;
            dot_done <= 1'b0;
            dot_acc  <= '0;
        end else begin
            if (dot_start)           acc_r <= 0;
            else if (dot_word_valid) acc_r <= acc_r + contrib(dot_a_word, dot_w_word);
            done_p   <= dot_word_valid & dot_last_word;
            dot_done <= done_p;
            if (done_p) dot_acc <= acc_r;
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic [ADDR_W-1:0] a_log[$];
    logic [ADDR_W-1:0] w_log[$];
    bit last_log[$];
    int rd_count = 0;
    int start_count = 0;
    int proto_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        bit prev_start = 1'b0;
        bit prev_wv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_start = 1'b0;
                prev_wv    = 1'b0;
            end else begin
                if (a_rd_en) begin
                    a_log.push_back(a_addr);
                    rd_count++;
                end
                if (w_rd_en) w_log.push_back(w_addr);
                if (dot_start) start_count++;
                if (dot_word_valid) last_log.push_back(dot_last_word);
                if (dot_start && dot_word_valid) proto_err++;
                if (prev_start && !dot_word_valid) proto_err++;
                if (dot_word_valid && !prev_wv && !prev_start) proto_err++;
                prev_start = dot_start;
                prev_wv    = dot_word_valid;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                    else                   check("rsp_acc", rsp_acc, exp_q.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] a_base;
        logic [ADDR_W-1:0] w_base;
        logic [LEN_W-1:0]  len;
        int                pat;
        int                exp_acc;
    } vec_t;

    logic [31:0] pop_w [4] = '{32'h0000FFFF, 32'h00000FFF, 32'h00FFFFFF, 32'h00000000};

    task automatic load_mem(input vec_t v);
        logic [ADDR_W-1:0] ai, wi;
        logic [31:0] r;
        for (int i = 0; i < int'(v.len); i++) begin
            ai = v.a_base + ADDR_W'(i);
            wi = v.w_base + ADDR_W'(i);
            r  = $urandom;
            case (v.pat)
                PAT_EQ:  begin a_mem[ai] = r;     w_mem[wi] = r;          end
                PAT_NOT: begin a_mem[ai] = r;     w_mem[wi] = ~r;         end
                PAT_POP: begin a_mem[ai] = '0;    w_mem[wi] = pop_w[i % 4]; end
                default: begin a_mem[ai] = '1;    w_mem[wi] = '1;         end
            endcase
        end
    endtask

    task automatic issue(input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] wb,
                         input logic [LEN_W-1:0] len, output int waited);
        bit ok = 1'b0;
        cmd_a_base = ab;
        cmd_w_base = wb;
        cmd_len    = len;
        cmd_valid  = 1'b1;
        waited     = 0;
        while (!ok && waited < 20) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            else           waited++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", ok, 1);
    endtask

    task automatic run_vector(input vec_t v, output int waited);
        int lat, rd0, st0;
        logic [ADDR_W-1:0] ea, ew;
        load_mem(v);
        a_log.delete();
        w_log.delete();
        last_log.delete();
        rd0 = rd_count;
        st0 = start_count;
        exp_q.push_back(v.exp_acc);
        issue(v.a_base, v.w_base, v.len, waited);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (v.len == 0) check("len0_rsp_within_2", int'(lat <= 2), 1);
        else            check("rsp_latency", lat, int'(v.len) + 3);
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("rsp_drained", exp_q.size(), 0);
        check("rd_count", rd_count - rd0, v.len);
        check("start_count", start_count - st0, (v.len != 0) ? 1 : 0);
        check("word_count", last_log.size(), v.len);
        for (int i = 0; i < a_log.size(); i++) begin
            ea = v.a_base + ADDR_W'(i);
            check("a_addr", a_log[i], ea);
        end
        for (int i = 0; i < w_log.size(); i++) begin
            ew = v.w_base + ADDR_W'(i);
            check("w_addr", w_log[i], ew);
        end
        for (int i = 0; i < last_log.size(); i++)
            check("last_word", last_log[i], (i == int'(v.len) - 1) ? 1 : 0);
    endtask

    vec_t vecs[6];

    initial begin : main
        int   waited;
        vec_t hv;
        vecs[0] = '{10'd0,    10'd0,   8'd8, PAT_EQ,   256};
        vecs[1] = '{10'd16,   10'd40,  8'd8, PAT_NOT, -256};
        vecs[2] = '{10'd100,  10'd200, 8'd4, PAT_POP,   24};
        vecs[3] = '{10'd1022, 10'd5,   8'd4, PAT_ONES, 128};
        vecs[4] = '{10'd7,    10'd7,   8'd1, PAT_NOT,  -32};
        vecs[5] = '{10'd3,    10'd9,   8'd0, PAT_EQ,     0};

        #1 rst_n = 1'b0;
        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rd_en", {a_rd_en, w_rd_en}, 0);
        check("rst_dot_strobes", {dot_start, dot_word_valid, dot_last_word}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_acc", rsp_acc, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_cmd_ready", cmd_ready, 1);

        for (int k = 0; k < 6; k++) run_vector(vecs[k], waited);

        // Response back-pressure, then a back-to-back command.
        hv = '{10'd50, 10'd60, 8'd3, PAT_EQ, 96};
        load_mem(hv);
        rsp_ready = 1'b0;
        exp_q.push_back(96);
        issue(hv.a_base, hv.w_base, hv.len, waited);
        for (int c = 0; c < 50 && !rsp_valid; c++) begin
            @(posedge clk);
            #1;
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_acc", rsp_acc, 96);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_cmd_ready", cmd_ready, 1);
        check("post_hs_rsp_valid", rsp_valid, 0);
        run_vector('{10'd500, 10'd600, 8'd5, PAT_NOT, -160}, waited);
        check("back_to_back_wait", waited, 0);

        // Reset during word 3 of an 8-word stream.
        hv = '{10'd200, 10'd210, 8'd8, PAT_EQ, 256};
        load_mem(hv);
        issue(hv.a_base, hv.w_base, hv.len, waited);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("midrst_word3_addr", a_addr, 203);
        rst_n = 1'b0;
        #1;
        check("midrst_strobes", {cmd_ready, a_rd_en, w_rd_en, dot_start,
                                 dot_word_valid, dot_last_word, rsp_valid}, 0);
        check("midrst_addrs", {a_addr, w_addr}, 0);
        check("midrst_rsp_acc", rsp_acc, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_rst_cmd_ready", cmd_ready, 1);
        run_vector('{10'd300, 10'd310, 8'd2, PAT_NOT, -64}, waited);

        repeat (4) @(posedge clk);
        check("start_word_valid_protocol", proto_err, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bnn_dot_word_feeder.md
Name: bnn_dot_word_feeder

Overview:
Command-driven streamer that feeds the XNOR-popcount dot unit from two packed binary SRAMs, one for activations and one for weights. It drives the dot unit's word-stream input (start, a_word, w_word, word_valid, last_word) and captures its done/acc_out. The signed dot product is returned on a valid/ready response port. It sits between the layer sequencer and the dot unit.

Parameters:
WORD_W, 32, packing width; must equal the dot unit's WORD_W
ADDR_W, 10, SRAM word-address width
LEN_W, 8, width of the word-count field; max vector = 2^LEN_W-1 words

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_a_base  in  ADDR_W  activation row base address
cmd_w_base  in  ADDR_W  weight row base address
cmd_len  in  LEN_W  number of words
a_rd_en  out  1  activation SRAM read enable
a_addr  out  ADDR_W  activation SRAM address
a_rdata  in  WORD_W  activation SRAM data, valid 1 cycle after a_rd_en
w_rd_en  out  1  weight SRAM read enable
w_addr  out  ADDR_W  weight SRAM address
w_rdata  in  WORD_W  weight SRAM data, valid 1 cycle after w_rd_en
dot_start  out  1  clears dot accumulator
dot_a_word  out  WORD_W  equals a_rdata
dot_w_word  out  WORD_W  equals w_rdata
dot_word_valid  out  1  word strobe
dot_last_word  out  1  final word marker
dot_done  in  1  dot unit result strobe
dot_acc  in  32 signed  dot unit result
rsp_valid  out  1  result valid
rsp_ready  in  1  result accepted
rsp_acc  out  32 signed  dot product

Behaviour:
- Async reset sets FSM to IDLE. All registered outputs go to 0: cmd_ready is 0 during reset and 1 after the first clk edge in IDLE; rd_en, dot_*, rsp_valid and rsp_acc are all 0. Reset mid-stream aborts without a response.
- FSM states: IDLE, START, STREAM, WAIT_DONE, RESP.
- IDLE: cmd_ready=1. On accept, latch the bases and len.
  - len=0: go to RESP with rsp_acc=0. No SRAM reads and no dot_start.
  - Otherwise: go to START.
- START (1 cycle): dot_start=1. Issue read of word 0 (both rd_en=1, addresses = bases). Then go to STREAM, or WAIT_DONE if len=1.
- STREAM: one read per cycle at base+i for i=1..len-1, with no bubbles. After the read for i=len-1, go to WAIT_DONE.
- Address arithmetic is modulo 2^ADDR_W, so it wraps silently.
- dot_word_valid and dot_last_word are rd_en and (i==len-1), each delayed one cycle, so they align with rdata.
- dot_a_word and dot_w_word are combinational passthroughs of the rdata ports.
- dot_start always precedes the first dot_word_valid by exactly 1 cycle. They are never asserted together.
- WAIT_DONE: on dot_done=1, capture dot_acc into rsp_acc and go to RESP. dot_done arriving in any other state is ignored.
- RESP: rsp_valid=1, and rsp_acc is held stable until rsp_ready. On handshake go to IDLE; cmd_ready=1 on the next cycle.
- Latency and throughput:
  - With accept at edge T, rsp_valid first rises after edge T+len+3.
  - Throughput is 1 word/cycle.
  - Between commands: 1 idle cycle minimum.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
Macro BNN_FEED_SIGN_OUT_EN.
- Defined: adds input cmd_thresh (32 signed, latched at accept) and output rsp_bit (1). rsp_bit = (captured acc >= thresh), valid with rsp_valid, reset 0. For len=0, rsp_bit = (0 >= thresh).
- Undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the FSM state enum;
  - WORD_W, ADDR_W and LEN_W defaults;
  - the dot-result width constant (32).
- One natural sub-module, bnn_feed_addr_ctr: base load, increment with wrap, last-index flag, and the 1-cycle valid/last delay pipe.

Test Plan:
- len=8, bases 0/0, a_rdata==w_rdata every word, against a behavioural dot unit -> rsp_acc=+256. rsp_valid first rises after edge T+11. dot_start is exactly one cycle before the first word_valid.
- len=8, w = ~a for all words -> rsp_acc=-256. len=4 with per-word XNOR popcounts 16,20,8,32 -> rsp_acc=(0)+8+(-16)+32=24.
- a_base=1022, w_base=5, len=4 -> a_addr sequence 1022,1023,0,1 and w_addr sequence 5..8. dot_last_word is high only on the 4th word_valid.
- cmd_len=0 -> no rd_en and no dot_start. rsp_valid is 1 within 2 cycles with rsp_acc=0.
- rsp_ready held low for 5 cycles -> rsp_acc stable and cmd_ready=0 throughout. After the handshake, a back-to-back command is accepted on the next cycle.
- rst_n asserted low mid-STREAM (word 3 of 8) -> all outputs 0 immediately. After release: IDLE with cmd_ready=1, and a fresh len=2 command completes correctly with no stale word_valid.
